// File: rtl/neopix_pkg.sv
// Shared types and helpers for the neopixel frame scheduler.
// Holds FSM states, count-width and refresh-period helpers.
package neopix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int START_TIMEOUT = 4;

  function automatic int cw_f(input int n);
    return $clog2(n) + 1;
  endfunction

  // hz == 0 disables refresh; keep a sane nonzero period anyway
  function automatic int period_f(input int clk_hz, input int hz);
    return (hz == 0) ? clk_hz : clk_hz / hz;
  endfunction

endpackage

// File: rtl/neopix_refresh_timer.sv
// Free-running refresh timer: counts 0..PERIOD-1, latches due.
// Ports: CLK, RESET, i_clear (reload + drop due), o_due.
module neopix_refresh_timer #(
  parameter int PERIOD = 100
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clear,
  output logic o_due
);

  localparam int TW = $clog2(PERIOD) + 1;
  localparam logic [TW-1:0] TERM = TW'(PERIOD - 1);

  logic [TW-1:0] r_cnt;
  logic          r_due;
  logic          w_term;

  assign w_term = (r_cnt == TERM);
  // due is visible in the terminal-count cycle itself
  assign o_due  = r_due | w_term;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= '0;
      r_due <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_due <= 1'b0;
    end else begin
      r_due <= r_due | w_term;
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/neopix_frame_sched.sv
// Frame scheduler: ping-pong bank ownership, swap and refresh starts.
// Ports: writer (wr_*), driver (ws_*, disp_*), auto_en, dropped, frames_shown.
module neopix_frame_sched
  import neopix_pkg::*;
#(
  parameter  int NUM_LEDS     = 8,
  parameter  int SYSTEM_CLOCK = 50000000,
  parameter  int REFRESH_HZ   = 30,
  localparam int CW           = cw_f(NUM_LEDS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_active,
  input  logic          wr_commit,
  input  logic [CW-1:0] wr_count,
  output logic          wr_bank,
  output logic          disp_bank,
  output logic [CW-1:0] disp_count,
  input  logic          ws_ready,
  output logic          ws_start,
  input  logic          auto_en,
  output logic          dropped,
  output logic [15:0]   frames_shown
);

  localparam int PERIOD = period_f(SYSTEM_CLOCK, REFRESH_HZ);
  localparam bit AUTO_ON = (REFRESH_HZ != 0);

  state_t        r_state;
  state_t        w_next;
  logic          r_wr_bank;
  logic          r_disp_bank;
  logic [CW-1:0] r_disp_count;
  logic [CW-1:0] r_pend_count;
  logic          r_pending;
  logic          r_ws_start;
  logic          r_dropped;
  logic [15:0]   r_frames;
  logic [1:0]    r_st_cnt;
  logic          w_due;
  logic          w_swap_ok;
  logic          w_ref_ok;
  logic          w_swap;
  logic          w_refresh;
  logic          w_st_to;
  logic [CW-1:0] w_clip;

  assign w_clip = (wr_count > CW'(NUM_LEDS)) ? CW'(NUM_LEDS) : wr_count;

  // a commit in the same cycle wins; swap retries next cycle
  assign w_swap_ok = r_pending & ws_ready & ~wr_active & ~wr_commit;
  assign w_ref_ok  = AUTO_ON & w_due & auto_en & ws_ready;
  assign w_st_to   = (r_st_cnt == 2'(START_TIMEOUT - 1));

  neopix_refresh_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_clear (w_swap | w_refresh),
    .o_due   (w_due)
  );

  always_comb begin
    w_next    = r_state;
    w_swap    = 1'b0;
    w_refresh = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_swap_ok) begin
          w_swap = 1'b1;
          w_next = START;
        end else if (w_ref_ok) begin
          w_refresh = 1'b1;
          w_next    = START;
        end
      end
      START: begin
        // driver may never drop ready; don't hang here
        if (!ws_ready || w_st_to) w_next = RUN;
      end
      RUN: begin
        if (ws_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_bank    <= 1'b0;
      r_disp_bank  <= 1'b1;
      r_disp_count <= '0;
      r_pend_count <= '0;
      r_pending    <= 1'b0;
      r_ws_start   <= 1'b0;
      r_dropped    <= 1'b0;
      r_frames     <= '0;
      r_st_cnt     <= '0;
    end else begin
      r_ws_start <= w_swap | w_refresh;
      r_dropped  <= wr_commit & r_pending;
      if (wr_commit) begin
        r_pending    <= 1'b1;
        r_pend_count <= w_clip;
      end else if (w_swap) begin
        r_pending <= 1'b0;
      end
      if (w_swap) begin
        r_disp_bank  <= r_wr_bank;
        r_wr_bank    <= r_disp_bank;
        r_disp_count <= r_pend_count;
      end
      if (r_state == RUN && ws_ready) r_frames <= r_frames + 16'd1;
      r_st_cnt <= (r_state == START) ? r_st_cnt + 2'd1 : 2'd0;
    end
  end

  assign wr_bank      = r_wr_bank;
  assign disp_bank    = r_disp_bank;
  assign disp_count   = r_disp_count;
  assign ws_start     = r_ws_start;
  assign dropped      = r_dropped;
  assign frames_shown = r_frames;

endmodule

// File: tb/tb_neopix_frame_sched.sv
// Directed bench for neopix_frame_sched (8 LEDs, 100-cycle refresh).
// Drives writer/driver handshakes and checks outputs after each edge.
module tb_neopix_frame_sched;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          wr_active;
  logic          wr_commit;
  logic [CW-1:0] wr_count;
  logic          wr_bank;
  logic          disp_bank;
  logic [CW-1:0] disp_count;
  logic          ws_ready;
  logic          ws_start;
  logic          auto_en;
  logic          dropped;
  logic [15:0]   frames_shown;

  int errs   = 0;
  int checks = 0;
  int cycno  = 0;
  int prev_s = -1;
  int iv     = 0;
  int busy   = 0;
  int n      = 0;
  bit drv_auto = 1'b0;
  bit seen;

  neopix_frame_sched #(
    .NUM_LEDS     (8),
    .SYSTEM_CLOCK (1000),
    .REFRESH_HZ   (10)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .wr_active    (wr_active),
    .wr_commit    (wr_commit),
    .wr_count     (wr_count),
    .wr_bank      (wr_bank),
    .disp_bank    (disp_bank),
    .disp_count   (disp_count),
    .ws_ready     (ws_ready),
    .ws_start     (ws_start),
    .auto_en      (auto_en),
    .dropped      (dropped),
    .frames_shown (frames_shown)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock; optional driver model busies ready for 5 edges
  task automatic cyc();
    @(posedge CLK);
    #1;
    cycno++;
    if (ws_start) begin
      iv     = (prev_s >= 0) ? cycno - prev_s : 0;
      prev_s = cycno;
    end
    if (drv_auto) begin
      if (ws_start) begin
        ws_ready = 1'b0;
        busy     = 5;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) ws_ready = 1'b1;
      end
    end
  endtask

  initial begin
    RESET     = 1'b1;
    wr_active = 1'b0;
    wr_commit = 1'b0;
    wr_count  = '0;
    ws_ready  = 1'b1;
    auto_en   = 1'b0;

    // 1: reset
    repeat (3) cyc();
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_disp_bank", disp_bank, 1);
    chk("rst_disp_count", disp_count, 0);
    chk("rst_ws_start", ws_start, 0);
    chk("rst_frames", frames_shown, 0);
    chk("rst_dropped", dropped, 0);
    RESET = 1'b0;
    cyc();

    // 2: commit 5 -> start two edges later, banks swap
    wr_count  = 4'd5;
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    chk("t2_start_k", ws_start, 0);
    cyc();
    chk("t2_start_k1", ws_start, 1);
    chk("t2_disp_bank", disp_bank, 0);
    chk("t2_wr_bank", wr_bank, 1);
    chk("t2_disp_count", disp_count, 5);
    cyc();
    chk("t2_start_pulse", ws_start, 0);
    ws_ready = 1'b0;
    cyc();
    cyc();
    chk("t2_frames_busy", frames_shown, 0);
    ws_ready = 1'b1;
    cyc();
    chk("t2_frames", frames_shown, 1);
    cyc();
    chk("t2_no_restart", ws_start, 0);

    // 3: two commits during RUN -> dropped, one swap with 6
    wr_count  = 4'd2;
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    cyc();
    chk("t3_start_a", ws_start, 1);
    chk("t3_count_a", disp_count, 2);
    chk("t3_disp_a", disp_bank, 1);
    ws_ready = 1'b0;
    cyc();
    wr_count  = 4'd3;
    wr_commit = 1'b1;
    cyc();
    chk("t3_drop_first", dropped, 0);
    wr_count = 4'd6;
    cyc();
    chk("t3_drop_second", dropped, 1);
    wr_commit = 1'b0;
    cyc();
    chk("t3_drop_pulse", dropped, 0);
    chk("t3_no_swap_run", disp_count, 2);
    ws_ready = 1'b1;
    cyc();
    chk("t3_frames", frames_shown, 2);
    chk("t3_idle_start", ws_start, 0);
    cyc();
    chk("t3_swap_start", ws_start, 1);
    chk("t3_swap_count", disp_count, 6);
    chk("t3_swap_disp", disp_bank, 0);
    chk("t3_swap_wr", wr_bank, 1);
    cyc();
    ws_ready = 1'b0;
    cyc();
    ws_ready = 1'b1;
    cyc();
    chk("t3_frames_end", frames_shown, 3);

    // 4: writer busy blocks swap, refresh every 100 cycles
    wr_active = 1'b1;
    wr_count  = 4'd4;
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    drv_auto  = 1'b1;
    auto_en   = 1'b1;
    prev_s    = -1;
    n         = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (ws_start) begin
        if (n > 0) chk("t4_interval", iv, 100);
        chk("t4_disp_bank", disp_bank, 0);
        chk("t4_disp_count", disp_count, 6);
        n++;
      end
    end
    chk("t4_nstarts_ge4", (n >= 4), 1);
    wr_active = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (ws_start) seen = 1'b1;
    end
    chk("t4_swap_seen", seen, 1);
    chk("t4_swap_disp", disp_bank, 1);
    chk("t4_swap_count", disp_count, 4);
    repeat (10) cyc();

    // 5: auto off -> silence; on -> start within 100
    auto_en = 1'b0;
    repeat (10) cyc();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (ws_start) n++;
    end
    chk("t5_silent", n, 0);
    auto_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc();
      if (ws_start) seen = 1'b1;
    end
    chk("t5_auto_start", seen, 1);
    auto_en = 1'b0;
    repeat (10) cyc();
    drv_auto = 1'b0;
    ws_ready = 1'b1;
    cyc();

    // 6: count clip, then reset while in RUN
    wr_count  = 4'd12;
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    cyc();
    chk("t6_start", ws_start, 1);
    chk("t6_clip", disp_count, 8);
    ws_ready = 1'b0;
    cyc();
    RESET = 1'b1;
    cyc();
    chk("t6_rst_wr_bank", wr_bank, 0);
    chk("t6_rst_disp_bank", disp_bank, 1);
    chk("t6_rst_count", disp_count, 0);
    chk("t6_rst_frames", frames_shown, 0);
    chk("t6_rst_start", ws_start, 0);
    RESET    = 1'b0;
    ws_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (ws_start) n++;
    end
    chk("t6_no_start", n, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
